// File: rtl/rx_prbs_checker_if.sv
// rtl/rx_prbs_checker_if.sv - sample stream and BER status bundle for rx_prbs_checker
//
// Purpose: groups the RX sample strike/data, the counter clear and the
// lock/BER status outputs of rx_prbs_checker into one interface.
// Signals:
//   cke_rx     sample strike (one clk_sys cycle per RX sample)
//   sig_rx     signed filter output, valid when cke_rx=1
//   clr_cnt    one-cycle clear of bit_count, err_count, lock_loss
//   locked     reference aligned and counting
//   bit_dec    last sliced bit
//   err_flag   one-cycle pulse: last counted sample mismatched
//   bit_count  bits compared while locked (saturating)
//   err_count  mismatches while locked (saturating)
//   lock_loss  LOCKED->SEED transitions (saturating at 255)
// Modports: master drives the stream side, slave is the checker.
interface rx_prbs_checker_if #(
  parameter int SIG_WIDTH = 16,
  parameter int CNT_WIDTH = 40
);
  logic                        cke_rx;
  logic signed [SIG_WIDTH-1:0] sig_rx;
  logic                        clr_cnt;
  logic                        locked;
  logic                        bit_dec;
  logic                        err_flag;
  logic [CNT_WIDTH-1:0]        bit_count;
  logic [CNT_WIDTH-1:0]        err_count;
  logic [7:0]                  lock_loss;

  modport master (
    output cke_rx, sig_rx, clr_cnt,
    input  locked, bit_dec, err_flag, bit_count, err_count, lock_loss
  );

  modport slave (
    input  cke_rx, sig_rx, clr_cnt,
    output locked, bit_dec, err_flag, bit_count, err_count, lock_loss
  );
endinterface

// File: rtl/rx_prbs_checker.sv
// rtl/rx_prbs_checker.sv - PRBS7 slicer, self-synchronising checker and BER counters
//
// Purpose: slices sig_rx on each cke_rx into a bit, self-synchronises a
// PRBS7 (x^7+x^6+1) reference to the bit stream and accumulates bit/error
// counts while locked. Everything advances only on cke_rx=1; all outputs are
// registered (one clk_sys of latency after the sampling edge).
// Ports:
//   clk_sys   system clock
//   rst       synchronous, active-high reset
//   bus       rx_prbs_checker_if.slave: cke_rx, sig_rx, clr_cnt in;
//             locked, bit_dec, err_flag, bit_count, err_count, lock_loss out
module rx_prbs_checker #(
  parameter int SIG_WIDTH  = 16,
  parameter int CNT_WIDTH  = 40,
  parameter int WIN        = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic                clk_sys,
  input  logic                rst,
  rx_prbs_checker_if.slave    bus
);

  localparam int WCW = $clog2(WIN);
  localparam int WEW = $clog2(WIN + 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [6:0]           lfsr_q, lfsr_d;
  logic [2:0]           seed_cnt_q, seed_cnt_d;
  logic [WCW-1:0]       win_cnt_q, win_cnt_d;
  logic [WEW-1:0]       win_err_q, win_err_d;
  logic                 locked_q, locked_d;
  logic                 bit_dec_q, bit_dec_d;
  logic                 err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [7:0]           lock_loss_q, lock_loss_d;

  logic                 slice_bit;
  logic                 exp_bit;
  logic                 mismatch;
  logic [6:0]           seed_lfsr;
  logic [WEW-1:0]       win_err_nx;
  logic                 win_end;
  logic                 count_en;
  logic                 lock_lost;

  // Zero slices to 1: the decision is simply the inverted sign bit.
  assign slice_bit  = ~bus.sig_rx[SIG_WIDTH-1];
  assign exp_bit    = lfsr_q[6] ^ lfsr_q[5];
  assign mismatch   = slice_bit ^ exp_bit;
  assign seed_lfsr  = {lfsr_q[5:0], slice_bit};
  assign win_end    = (win_cnt_q == WCW'(WIN - 1));
  // Window error count including the current sample, saturating at WIN.
  assign win_err_nx = (mismatch && (win_err_q != WEW'(WIN))) ? win_err_q + 1'b1 : win_err_q;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_dec_d   = bit_dec_q;
    err_flag_d  = 1'b0;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    lock_loss_d = lock_loss_q;
    count_en    = 1'b0;
    lock_lost   = 1'b0;

    if (bus.cke_rx) begin
      bit_dec_d = slice_bit;
      case (state_q)
        SEED: begin
          lfsr_d = seed_lfsr;
          if (seed_cnt_q == 3'd6) begin
            seed_cnt_d = 3'd0;
            // An all-zero seed would verify trivially on a stuck-low line.
            if (seed_lfsr != 7'h00) begin
              state_d   = VERIFY;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          lfsr_d    = {lfsr_q[5:0], exp_bit};
          win_err_d = win_err_nx;
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_nx == '0) begin
              state_d = LOCKED;
            end else begin
              state_d    = SEED;
              seed_cnt_d = 3'd0;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          lfsr_d     = {lfsr_q[5:0], exp_bit};
          win_err_d  = win_err_nx;
          count_en   = ~bus.clr_cnt;
          err_flag_d = mismatch & ~bus.clr_cnt;
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_nx >= WEW'(ERR_THRESH)) begin
              state_d    = SEED;
              seed_cnt_d = 3'd0;
              lock_lost  = 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = SEED;
        end
      endcase
    end

    // A clear in the same cycle as a counted sample wins; the sample is dropped.
    if (bus.clr_cnt) begin
      bit_count_d = '0;
      err_count_d = '0;
      lock_loss_d = 8'h00;
    end else begin
      if (count_en && (bit_count_q != '1)) begin
        bit_count_d = bit_count_q + 1'b1;
      end
      if (count_en && mismatch && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
      if (lock_lost && (lock_loss_q != 8'hFF)) begin
        lock_loss_d = lock_loss_q + 1'b1;
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= SEED;
      lfsr_q      <= 7'h00;
      seed_cnt_q  <= 3'd0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      bit_dec_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
      lock_loss_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      bit_dec_q   <= bit_dec_d;
      err_flag_q  <= err_flag_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.bit_dec   = bit_dec_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;
  assign bus.lock_loss = lock_loss_q;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// tb/tb_rx_prbs_checker.sv - directed bench for rx_prbs_checker
module tb_rx_prbs_checker;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  always #5 clk_sys = ~clk_sys;

  rx_prbs_checker_if #(.SIG_WIDTH(16), .CNT_WIDTH(40)) ia ();
  rx_prbs_checker_if #(.SIG_WIDTH(16), .CNT_WIDTH(4))  ib ();

  rx_prbs_checker #(.SIG_WIDTH(16), .CNT_WIDTH(40), .WIN(64), .ERR_THRESH(8)) dut_a (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (ia.slave)
  );

  rx_prbs_checker #(.SIG_WIDTH(16), .CNT_WIDTH(4), .WIN(64), .ERR_THRESH(8)) dut_b (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (ib.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] gen   = 7'h5A;
  logic       last_bit;
  logic       flag_seen;
  logic       flag_hold;
  int         flags;
  int         hold_bad;
  int         locked_any;
  int         dec_ones;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One RX sample: strike for one cycle, then three idle cycles (cke every 4 clk).
  task automatic send_raw(input logic sel, input logic signed [15:0] s, input logic clr);
    if (sel) begin
      ib.cke_rx = 1'b1; ib.sig_rx = s; ib.clr_cnt = clr;
    end else begin
      ia.cke_rx = 1'b1; ia.sig_rx = s; ia.clr_cnt = clr;
    end
    tick();
    flag_seen = sel ? ib.err_flag : ia.err_flag;
    ia.cke_rx = 1'b0; ia.clr_cnt = 1'b0;
    ib.cke_rx = 1'b0; ib.clr_cnt = 1'b0;
    tick();
    flag_hold = sel ? ib.err_flag : ia.err_flag;
    repeat (2) tick();
  endtask

  // Next PRBS7 bit (x^7+x^6+1), optionally inverted on the line.
  task automatic gen_send(input logic sel, input logic inv, input logic clr);
    logic b;
    b        = gen[6] ^ gen[5];
    gen      = {gen[5:0], b};
    last_bit = b ^ inv;
    send_raw(sel, last_bit ? 16'sd1000 : -16'sd1000, clr);
  endtask

  initial begin
    ia.cke_rx = 1'b0; ia.sig_rx = '0; ia.clr_cnt = 1'b0;
    ib.cke_rx = 1'b0; ib.sig_rx = '0; ib.clr_cnt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_locked",    ia.locked,    0);
    chk("rst_bit_dec",   ia.bit_dec,   0);
    chk("rst_err_flag",  ia.err_flag,  0);
    chk("rst_bit_count", ia.bit_count, 0);
    chk("rst_err_count", ia.err_count, 0);
    chk("rst_lock_loss", ia.lock_loss, 0);

    // Clean stream: lock after 7 seed + 64 verify samples.
    for (int i = 0; i < 70; i++) gen_send(0, 0, 0);
    chk("acq_locked_70", ia.locked, 0);
    gen_send(0, 0, 0);
    chk("acq_locked_71", ia.locked, 1);
    chk("acq_bit_dec",   ia.bit_dec, last_bit);
    chk("acq_bit_count", ia.bit_count, 0);
    chk("acq_err_count", ia.err_count, 0);

    // One inverted bit every 16 samples: 4 errors in one window, lock kept.
    flags = 0; hold_bad = 0;
    for (int i = 0; i < 64; i++) begin
      gen_send(0, (i % 16) == 0, 0);
      flags += int'(flag_seen);
      hold_bad += int'(flag_hold);
    end
    chk("sparse_flags",     flags, 4);
    chk("sparse_flag_hold", hold_bad, 0);
    chk("sparse_bit_count", ia.bit_count, 64);
    chk("sparse_err_count", ia.err_count, 4);
    chk("sparse_locked",    ia.locked, 1);
    chk("sparse_lock_loss", ia.lock_loss, 0);

    // Whole window inverted: lock drops exactly at the window end.
    flags = 0;
    for (int i = 0; i < 63; i++) begin
      gen_send(0, 1, 0);
      flags += int'(flag_seen);
    end
    chk("inv_locked_63", ia.locked, 1);
    gen_send(0, 1, 0);
    flags += int'(flag_seen);
    chk("inv_locked_64", ia.locked, 0);
    chk("inv_flags",     flags, 64);
    chk("inv_lock_loss", ia.lock_loss, 1);
    chk("inv_err_count", ia.err_count, 68);
    chk("inv_bit_count", ia.bit_count, 128);

    // Relock on clean data.
    for (int i = 0; i < 70; i++) gen_send(0, 0, 0);
    chk("relock_70", ia.locked, 0);
    gen_send(0, 0, 0);
    chk("relock_71",        ia.locked, 1);
    chk("relock_bit_count", ia.bit_count, 128);

    // Clear coincident with a counted sample: clear wins.
    gen_send(0, 0, 1);
    chk("clr_bit_count", ia.bit_count, 0);
    chk("clr_err_count", ia.err_count, 0);
    chk("clr_lock_loss", ia.lock_loss, 0);
    gen_send(0, 0, 0);
    chk("clr_next_count", ia.bit_count, 1);

    // Stuck-low input never locks.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    locked_any = 0; dec_ones = 0;
    for (int i = 0; i < 500; i++) begin
      send_raw(0, -16'sd5, 0);
      locked_any += int'(ia.locked);
      dec_ones += int'(ia.bit_dec);
    end
    chk("zero_locked",    locked_any, 0);
    chk("zero_bit_dec",   dec_ones, 0);
    chk("zero_bit_count", ia.bit_count, 0);
    chk("zero_err_count", ia.err_count, 0);
    send_raw(0, 16'sd0, 0);
    chk("slice_zero_is_one", ia.bit_dec, 1);

    // Narrow counters: saturate at 15; err_flag still pulses after saturation.
    for (int i = 0; i < 71; i++) gen_send(1, 0, 0);
    chk("b_locked", ib.locked, 1);
    for (int i = 0; i < 20; i++) gen_send(1, i == 19, 0);
    chk("b_sat_bit_count", ib.bit_count, 15);
    chk("b_sat_err_flag",  flag_seen, 1);
    chk("b_sat_err_count", ib.err_count, 1);

    // Reset mid-window overrides a coincident strike and clear.
    ib.cke_rx = 1'b1; ib.clr_cnt = 1'b1; ib.sig_rx = 16'sd1000;
    rst = 1'b1;
    tick();
    ib.cke_rx = 1'b0; ib.clr_cnt = 1'b0;
    chk("b_rst_locked",    ib.locked,    0);
    chk("b_rst_bit_dec",   ib.bit_dec,   0);
    chk("b_rst_err_flag",  ib.err_flag,  0);
    chk("b_rst_bit_count", ib.bit_count, 0);
    chk("b_rst_err_count", ib.err_count, 0);
    chk("b_rst_lock_loss", ib.lock_loss, 0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
